// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Round-robin arbiter that shares one 7-segment digit between two requesters.
// A grant is held for at least HOLD_CYCLES cycles so the digit does not flicker.
// The granted requester's 4-bit value is hex-decoded onto the active-low segments.
`timescale 1ns/1ps
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 12_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Req_0,
  input  logic [3:0] i_Data_0,
  input  logic       i_Req_1,
  input  logic [3:0] i_Data_1,
  output logic       o_Grant_0,
  output logic       o_Grant_1,
  output logic       o_Busy,
  output logic       o_Segment1_A,
  output logic       o_Segment1_B,
  output logic       o_Segment1_C,
  output logic       o_Segment1_D,
  output logic       o_Segment1_E,
  output logic       o_Segment1_F,
  output logic       o_Segment1_G
);

  // Counter is at least one bit wide so HOLD_CYCLES=1 still elaborates.
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Hex digit to segment pattern, bit order GFEDCBA, active high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'b0111111;
      4'h1:    p = 7'b0000110;
      4'h2:    p = 7'b1011011;
      4'h3:    p = 7'b1001111;
      4'h4:    p = 7'b1100110;
      4'h5:    p = 7'b1101101;
      4'h6:    p = 7'b1111101;
      4'h7:    p = 7'b0000111;
      4'h8:    p = 7'b1111111;
      4'h9:    p = 7'b1101111;
      4'hA:    p = 7'b1110111;
      4'hB:    p = 7'b1111100;
      4'hC:    p = 7'b0111001;
      4'hD:    p = 7'b1011110;
      4'hE:    p = 7'b1111001;
      4'hF:    p = 7'b1110001;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  state_t          r_state;
  logic            r_ptr;      // 1: requester 1 is favoured on a tie
  logic [CW-1:0]   r_hold;
  logic [3:0]      r_value;

  state_t          w_next_state;
  logic            w_grant;    // a new owner is selected this edge
  logic            w_grant_to; // which requester receives that grant
  logic            w_hold_exp;
  logic [CW-1:0]   w_next_hold;
  logic [3:0]      w_next_value;
  logic            w_next_ptr;
  logic            w_busy;
  logic [6:0]      w_seg_n;

  // Next-state selection: arbitration from IDLE and handoff/release after hold expiry.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_to   = 1'b0;
    w_hold_exp   = (r_hold == HOLD_MAX);
    case (r_state)
      IDLE: begin
        if (i_Req_0 && (!i_Req_1 || !r_ptr)) begin
          w_grant    = 1'b1;
          w_grant_to = 1'b0;
        end else if (i_Req_1) begin
          w_grant    = 1'b1;
          w_grant_to = 1'b1;
        end else begin
          w_grant    = 1'b0;
        end
      end
      OWN0: begin
        if (w_hold_exp && i_Req_1) begin
          w_grant    = 1'b1;
          w_grant_to = 1'b1;
        end else if (w_hold_exp && !i_Req_0) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = OWN0;
        end
      end
      OWN1: begin
        if (w_hold_exp && i_Req_0) begin
          w_grant    = 1'b1;
          w_grant_to = 1'b0;
        end else if (w_hold_exp && !i_Req_1) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = OWN1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (w_grant) begin
      w_next_state = w_grant_to ? OWN1 : OWN0;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // Next values for the value latch, hold counter and round-robin pointer.
  always_comb begin
    w_next_value = r_value;
    w_next_hold  = r_hold;
    w_next_ptr   = r_ptr;
    if (w_grant) begin
      w_next_value = w_grant_to ? i_Data_1 : i_Data_0;
      w_next_hold  = {CW{1'b0}};
      w_next_ptr   = ~w_grant_to;
    end else if (w_next_state != IDLE) begin
      if ((r_state == OWN0) && i_Req_0) begin
        w_next_value = i_Data_0;
      end else if ((r_state == OWN1) && i_Req_1) begin
        w_next_value = i_Data_1;
      end else begin
        w_next_value = r_value;
      end
      w_next_hold = w_hold_exp ? r_hold : (r_hold + {{(CW-1){1'b0}}, 1'b1});
    end else begin
      w_next_hold = {CW{1'b0}};
    end
  end

  // State, counter, value and pointer registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= IDLE;
      r_hold  <= {CW{1'b0}};
      r_value <= 4'h0;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_hold  <= w_next_hold;
      r_value <= w_next_value;
      r_ptr   <= w_next_ptr;
    end
  end

  // Outputs decoded only from registered state and value; blank when idle.
  assign o_Grant_0 = (r_state == OWN0);
  assign o_Grant_1 = (r_state == OWN1);
  assign w_busy    = o_Grant_0 | o_Grant_1;
  assign o_Busy    = w_busy;
  assign w_seg_n   = w_busy ? ~hex_to_seg(r_value) : 7'b1111111;

  assign o_Segment1_A = w_seg_n[0];
  assign o_Segment1_B = w_seg_n[1];
  assign o_Segment1_C = w_seg_n[2];
  assign o_Segment1_D = w_seg_n[3];
  assign o_Segment1_E = w_seg_n[4];
  assign o_Segment1_F = w_seg_n[5];
  assign o_Segment1_G = w_seg_n[6];

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Two-requester arbiter for the single 7-segment digit (Segment1). Each requester asks for the display with a level request and a 4-bit value. The granted requester's value is hex-decoded onto the active-low segment outputs. Round-robin arbitration with a minimum hold time lets a decimal counter and a status/error source share one digit without flicker.

Parameters:
HOLD_CYCLES, 12_500_000, minimum consecutive cycles a grant is held (>=1); reduced to small values for simulation.

Ports:
i_Clk  in  1  system clock (25 MHz)
i_Rst_L  in  1  asynchronous active-low reset
i_Req_0  in  1  requester 0 wants the display (level)
i_Data_0  in  4  requester 0 value, 0x0-0xF
i_Req_1  in  1  requester 1 wants the display (level)
i_Data_1  in  4  requester 1 value
o_Grant_0  out  1  requester 0 owns the display
o_Grant_1  out  1  requester 1 owns the display
o_Busy  out  1  display owned by either requester
o_Segment1_A..o_Segment1_G  out  1 each  segment drives, active low

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, grants 0, o_Busy 0, hold count 0
  - round-robin pointer favours requester 0
  - all segment outputs 1 (blank).
- States: IDLE, OWN0, OWN1. All outputs are registered, or decoded combinationally from registered state/value only.
- IDLE:
  - At the edge where any request is high, enter OWNn. The grant rises that edge.
  - Both requests high: grant the pointer's favourite.
  - Pointer update on every grant: favour the other requester.
- Value latch:
  - On the grant edge, and on every edge while in OWNn with i_Req_n high, the value register captures i_Data_n.
  - While i_Req_n is low, the value freezes.
  - Segments therefore change on the same edge as the grant.
- Hold count:
  - Cleared on every grant edge. Increments per OWN cycle, saturating at HOLD_CYCLES-1.
  - Hold is expired when count == HOLD_CYCLES-1.
  - No transition out of OWNn occurs before expiry, even if i_Req_n drops.
  - HOLD_CYCLES=1 means a decision is made every cycle.
- OWNn with hold expired, evaluated each edge:
  - Other request high: direct handoff to OWNm at one edge. o_Grant_n falls and o_Grant_m rises on the same edge. Value is captured from i_Data_m. This preempts even if i_Req_n is still high.
  - Else if i_Req_n high: stay in OWNn; the count stays saturated.
  - Else: go to IDLE, grants 0, display blank.
- o_Grant_0 and o_Grant_1 are never high together. o_Busy = o_Grant_0 | o_Grant_1.
- Decode (GFEDCBA, active high before inversion):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Outputs are the inverted pattern when busy, and all 1 when IDLE.
- Reset asserted mid-grant: immediate return to the reset values above. The pointer returns to favouring requester 0.

Test Plan:
(All scenarios use HOLD_CYCLES=4.)
1. Reset, then no requests for 10 cycles -> grants 0, o_Busy 0, all seven segment outputs 1.
2. i_Req_0=1, i_Data_0=3 -> next edge o_Grant_0=1, outputs {G..A}=0110000. Change i_Data_0 to 8 -> following edge outputs 0000000.
3. i_Req_0 and i_Req_1 rise on the same edge after reset, data 5 and 0xA:
   - Requester 0 is granted first; outputs {G..A}=0010010.
   - Both requests held: after exactly 4 grant cycles, o_Grant_1 rises as o_Grant_0 falls on the same edge; outputs 0001000.
   - 4 cycles later, handoff back to requester 0.
4. Requester 0 owns with value 7; i_Req_0 drops after 1 cycle, requester 1 idle -> display stays 7 (outputs 1111000) until 4 grant cycles elapse. Then IDLE, outputs all 1, o_Busy 0.
5. Requester 1 alone granted, holds 20 cycles -> grant stays uninterrupted. i_Req_0 rises at cycle 20 -> handoff on the next edge.
6. Assert i_Rst_L=0 mid-grant, between clock edges -> grants, o_Busy and segments return to reset values immediately without a clock edge. After release, simultaneous requests are granted to requester 0 first.
